// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Shared types for the systolic-array datapath: skew mode and
//               skew-buffer FSM encodings, plus the lane tap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

  typedef enum logic {SKEW_MODE = 1'b0, DESKEW_MODE = 1'b1} skew_mode_e;

  typedef enum logic [1:0] {
    SK_IDLE   = 2'd0,
    SK_STREAM = 2'd1,
    SK_DRAIN  = 2'd2
  } skew_state_e;

  // Zero-based stage index holding a beat that entered lane_delay cycles ago.
  function automatic int lane_tap(input skew_mode_e mode, input int lane,
                                  input int n, input int base_lat);
    return (mode == SKEW_MODE) ? (base_lat - 1 + lane)
                               : (base_lat - 1 + (n - 1 - lane));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : lane_delay_line
// Description : Single-lane shift register of {v,f,l,data} with a runtime
//               selectable output tap; data is zero-gated by the tap's v bit.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_delay_line #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TAP_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  adv,
  input  logic                  in_v,
  input  logic                  in_f,
  input  logic                  in_l,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [TAP_W-1:0]      tap,
  output logic                  out_v,
  output logic                  out_f,
  output logic                  out_l,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]                 v_q, v_d, f_q, f_d, l_q, l_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;

  // Clear only drops the tags; stale data is masked by v at the tap.
  always_comb begin
    v_d    = v_q;
    f_d    = f_q;
    l_d    = l_q;
    data_d = data_q;
    if (clr) begin
      v_d = '0;
      f_d = '0;
      l_d = '0;
    end else if (adv) begin
      v_d    = {v_q[DEPTH-2:0], in_v};
      f_d    = {f_q[DEPTH-2:0], in_f};
      l_d    = {l_q[DEPTH-2:0], in_l};
      data_d = {data_q[DEPTH-2:0], in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      f_q    <= '0;
      l_q    <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      f_q    <= f_d;
      l_q    <= l_d;
      data_q <= data_d;
    end
  end

  assign out_v    = v_q[tap];
  assign out_f    = f_q[tap];
  assign out_l    = l_q[tap];
  assign out_data = v_q[tap] ? data_q[tap] : '0;

endmodule
`default_nettype wire

// File: rtl/stream_skew_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stream_skew_buffer
// Description : Backpressure-aware lane skewer/deskewer with burst framing,
//               automatic drain and per-lane zero gating.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skew_buffer
  import npu_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BASE_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    cfg_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic [N-1:0]            out_lane_v,
  output logic                    first_out,
  output logic                    last_out,
  output logic                    busy,
  output logic                    done
);

  localparam int D     = BASE_LAT + N - 1;
  localparam int CNT_W = $clog2(D);
  localparam logic [N-1:0] LANE_LO = N'(1);
  localparam logic [N-1:0] LANE_HI = {1'b1, {(N-1){1'b0}}};

  skew_state_e      state_q, state_d;
  skew_mode_e       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic         adv, accept;
  logic         tag_v, tag_f, tag_l, done_w;
  logic [N-1:0] lane_f, lane_l;

  assign adv      = out_ready;
  assign in_ready = adv && (state_q != SK_DRAIN);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    tag_v   = 1'b0;
    tag_f   = 1'b0;
    tag_l   = 1'b0;
    done_w  = 1'b0;
    if (flush) begin
      state_d = SK_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SK_IDLE: begin
          // Beats without in_first are consumed as bubbles.
          if (accept && in_first) begin
            mode_d  = skew_mode_e'(cfg_mode);
            tag_v   = 1'b1;
            tag_f   = 1'b1;
            tag_l   = in_last;
            cnt_d   = '0;
            state_d = in_last ? SK_DRAIN : SK_STREAM;
          end
        end
        SK_STREAM: begin
          if (accept) begin
            tag_v = 1'b1;
            tag_l = in_last;
            if (in_last) begin
              state_d = SK_DRAIN;
              cnt_d   = '0;
            end
          end
        end
        SK_DRAIN: begin
          if (adv) begin
            if (cnt_q == CNT_W'(D - 1)) begin
              done_w  = 1'b1;
              state_d = SK_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = SK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SK_IDLE;
      mode_q  <= SKEW_MODE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [CNT_W-1:0] tap;
    assign tap = CNT_W'(lane_tap(mode_q, i, N, BASE_LAT));

    lane_delay_line #(
      .DEPTH      (D),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_line (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .adv      (adv),
      .in_v     (tag_v),
      .in_f     (tag_f),
      .in_l     (tag_l),
      .in_data  (in_data[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]),
      .tap      (tap),
      .out_v    (out_lane_v[i]),
      .out_f    (lane_f[i]),
      .out_l    (lane_l[i]),
      .out_data (out_data[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH])
    );
  end

  // Row 0 leaves through the shortest lane, the last row through the longest.
  assign first_out = |(lane_f & ((mode_q == SKEW_MODE) ? LANE_LO : LANE_HI));
  assign last_out  = |(lane_l & ((mode_q == SKEW_MODE) ? LANE_HI : LANE_LO));
  assign busy      = (state_q != SK_IDLE);
  assign done      = done_w;

endmodule
`default_nettype wire

// File: tb/tb_stream_skew_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_skew_buffer
// Description : Directed, table-driven bench for stream_skew_buffer (N=4,
//               8-bit lanes, BASE_LAT=1); lane i of row r carries r*10+i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_skew_buffer;

  typedef struct {
    logic        valid, first, last, mode, rdy, flush;
    int          row;
    logic        irdy;
    logic [3:0]  lv;
    logic [31:0] data;
    logic        fo, lo, bz, dn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, cfg_mode = 1'b0, in_valid = 1'b0;
  logic        in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_ready, first_out, last_out, busy, done;
  logic [31:0] out_data;
  logic [3:0]  out_lane_v;

  int checks = 0;
  int errors = 0;
  vec_t tbl[38];

  always #5 clk = ~clk;

  stream_skew_buffer #(.N(4), .DATA_WIDTH(8), .BASE_LAT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_last(in_last), .in_data(in_data), .out_ready(out_ready),
    .out_data(out_data), .out_lane_v(out_lane_v), .first_out(first_out),
    .last_out(last_out), .busy(busy), .done(done)
  );

  function automatic logic [31:0] mk_row(input int r);
    logic [31:0] d = '0;
    if (r != 0)
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'(r * 10 + i);
    return d;
  endfunction

  function automatic vec_t mkv(input logic valid, first, last, mode, rdy, fl,
                               input int row, input logic irdy,
                               input logic [3:0] lv, input logic [31:0] data,
                               input logic fo, lo, bz, dn);
    vec_t v;
    v.valid = valid; v.first = first; v.last = last; v.mode = mode;
    v.rdy = rdy; v.flush = fl; v.row = row; v.irdy = irdy; v.lv = lv;
    v.data = data; v.fo = fo; v.lo = lo; v.bz = bz; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " in_ready"},   32'(in_ready),   32'(v.irdy));
    chk({tag, " out_lane_v"}, 32'(out_lane_v), 32'(v.lv));
    chk({tag, " out_data"},   out_data,        v.data);
    chk({tag, " first_out"},  32'(first_out),  32'(v.fo));
    chk({tag, " last_out"},   32'(last_out),   32'(v.lo));
    chk({tag, " busy"},       32'(busy),       32'(v.bz));
    chk({tag, " done"},       32'(done),       32'(v.dn));
  endtask

  // Entered at posedge+1; drives one cycle, checks at negedge.
  task automatic apply(input vec_t v, input string tag);
    in_valid = v.valid; in_first = v.first; in_last = v.last;
    cfg_mode = v.mode;  out_ready = v.rdy;  flush = v.flush;
    in_data  = mk_row(v.row);
    @(negedge clk);
    chk_all(tag, v);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int lo_idx, input int hi_idx, input string tag);
    for (int k = lo_idx; k <= hi_idx; k++) apply(tbl[k], $sformatf("%s[%0d]", tag, k));
  endtask

  initial begin
    vec_t z, fv;
    z = mkv(0,0,0,0,1,0, 0, 1, 4'h0, 32'h0, 0,0,0,0);

    // SKEW burst rows 1..4: lane i delay i+1
    tbl[0]  = mkv(1,1,0,0,1,0, 1, 1, 4'h0, 32'h00000000, 0,0,0,0);
    tbl[1]  = mkv(1,0,0,0,1,0, 2, 1, 4'h1, 32'h0000000A, 1,0,1,0);
    tbl[2]  = mkv(1,0,0,0,1,0, 3, 1, 4'h3, 32'h00000B14, 0,0,1,0);
    tbl[3]  = mkv(1,0,1,0,1,0, 4, 1, 4'h7, 32'h000C151E, 0,0,1,0);
    tbl[4]  = mkv(0,0,0,0,1,0, 0, 0, 4'hF, 32'h0D161F28, 0,0,1,0);
    tbl[5]  = mkv(0,0,0,0,1,0, 0, 0, 4'hE, 32'h17202900, 0,0,1,0);
    tbl[6]  = mkv(0,0,0,0,1,0, 0, 0, 4'hC, 32'h212A0000, 0,0,1,0);
    tbl[7]  = mkv(0,0,0,0,1,0, 0, 0, 4'h8, 32'h2B000000, 0,1,1,1);
    // DESKEW burst back-to-back; cfg_mode toggles mid-burst must be ignored
    tbl[8]  = mkv(1,1,0,1,1,0, 1, 1, 4'h0, 32'h00000000, 0,0,0,0);
    tbl[9]  = mkv(1,0,0,0,1,0, 2, 1, 4'h8, 32'h0D000000, 1,0,1,0);
    tbl[10] = mkv(1,0,0,1,1,0, 3, 1, 4'hC, 32'h170C0000, 0,0,1,0);
    tbl[11] = mkv(1,0,1,0,1,0, 4, 1, 4'hE, 32'h21160B00, 0,0,1,0);
    tbl[12] = mkv(0,0,0,0,1,0, 0, 0, 4'hF, 32'h2B20150A, 0,0,1,0);
    tbl[13] = mkv(0,0,0,0,1,0, 0, 0, 4'h7, 32'h002A1F14, 0,0,1,0);
    tbl[14] = mkv(0,0,0,0,1,0, 0, 0, 4'h3, 32'h0000291E, 0,0,1,0);
    tbl[15] = mkv(0,0,0,0,1,0, 0, 0, 4'h1, 32'h00000028, 0,1,1,1);
    // SKEW burst with a 3-cycle out_ready stall before row 3
    tbl[16] = mkv(1,1,0,0,1,0, 1, 1, 4'h0, 32'h00000000, 0,0,0,0);
    tbl[17] = mkv(1,0,0,0,1,0, 2, 1, 4'h1, 32'h0000000A, 1,0,1,0);
    tbl[18] = mkv(1,0,0,0,0,0, 3, 0, 4'h3, 32'h00000B14, 0,0,1,0);
    tbl[19] = mkv(1,0,0,0,0,0, 3, 0, 4'h3, 32'h00000B14, 0,0,1,0);
    tbl[20] = mkv(1,0,0,0,0,0, 3, 0, 4'h3, 32'h00000B14, 0,0,1,0);
    tbl[21] = mkv(1,0,0,0,1,0, 3, 1, 4'h3, 32'h00000B14, 0,0,1,0);
    tbl[22] = mkv(1,0,1,0,1,0, 4, 1, 4'h7, 32'h000C151E, 0,0,1,0);
    tbl[23] = mkv(0,0,0,0,1,0, 0, 0, 4'hF, 32'h0D161F28, 0,0,1,0);
    tbl[24] = mkv(0,0,0,0,1,0, 0, 0, 4'hE, 32'h17202900, 0,0,1,0);
    tbl[25] = mkv(0,0,0,0,1,0, 0, 0, 4'hC, 32'h212A0000, 0,0,1,0);
    tbl[26] = mkv(0,0,0,0,1,0, 0, 0, 4'h8, 32'h2B000000, 0,1,1,1);
    // single-beat burst, row 5
    tbl[27] = mkv(1,1,1,0,1,0, 5, 1, 4'h0, 32'h00000000, 0,0,0,0);
    tbl[28] = mkv(0,0,0,0,1,0, 0, 0, 4'h1, 32'h00000032, 1,0,1,0);
    tbl[29] = mkv(0,0,0,0,1,0, 0, 0, 4'h2, 32'h00003300, 0,0,1,0);
    tbl[30] = mkv(0,0,0,0,1,0, 0, 0, 4'h4, 32'h00340000, 0,0,1,0);
    tbl[31] = mkv(0,0,0,0,1,0, 0, 0, 4'h8, 32'h35000000, 0,1,1,1);
    // stray beat in IDLE without in_first
    tbl[32] = mkv(1,0,0,0,1,0, 6, 1, 4'h0, 32'h00000000, 0,0,0,0);
    for (int k = 33; k < 38; k++) tbl[k] = z;

    // asynchronous reset, no clock edge needed
    #1 rst = 1'b1;
    #1 chk_all("reset", z);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    run(0, 37, "tbl");

    // flush during DRAIN: 2-beat burst, flush on the second drain cycle
    apply(mkv(1,1,0,0,1,0, 1, 1, 4'h0, 32'h00000000, 0,0,0,0), "flush0");
    apply(mkv(1,0,1,0,1,0, 2, 1, 4'h1, 32'h0000000A, 1,0,1,0), "flush1");
    apply(mkv(0,0,0,0,1,0, 0, 0, 4'h3, 32'h00000B14, 0,0,1,0), "flush2");
    apply(mkv(0,0,0,0,1,1, 0, 0, 4'h6, 32'h000C1500, 0,0,1,0), "flush3");
    for (int k = 0; k < 5; k++) apply(z, $sformatf("post_flush%0d", k));
    run(0, 7, "after_flush");
    apply(z, "after_flush_idle");

    // async reset mid-STREAM
    run(0, 2, "pre_rst");
    fv = tbl[3];
    in_valid = fv.valid; in_first = fv.first; in_last = fv.last;
    in_data = mk_row(fv.row);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", z);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = '0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    run(32, 37, "post_rst_stray");
    run(0, 7, "post_rst");
    apply(z, "post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
